// File: rtl/day_4_pkg.sv
// day_4_pkg: shared definitions for the day-4 erosion pass scheduler.
// Holds the FSM state encoding, the default grid geometry and the
// neighbour threshold below which an occupied cell is eroded.
package day_4_pkg;

  localparam int DEF_WIDTH    = 140;
  localparam int DEF_HEIGHT   = 140;
  localparam int NEIGH_THRESH = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    STREAM = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/day_4_row_eval.sv
// day_4_row_eval: combinational evaluation of one grid row.
// Given the row above, the current row and the row below, it returns the
// surviving cells of the current row and how many cells were eroded.
// Columns outside the row are treated as empty.
module day_4_row_eval
  import day_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]             above,
  input  logic [WIDTH-1:0]             cur,
  input  logic [WIDTH-1:0]             below,
  output logic [WIDTH-1:0]             keep,
  output logic [$clog2(WIDTH+1)-1:0]   removed
);

  localparam int RM_W = $clog2(WIDTH+1);

  // Zero padding on both sides makes the edge columns see empty neighbours.
  logic [WIDTH+1:0] a_p, c_p, b_p;

  assign a_p = {1'b0, above, 1'b0};
  assign c_p = {1'b0, cur,   1'b0};
  assign b_p = {1'b0, below, 1'b0};

  // Column c lives at padded index c+1; its neighbours sit at c, c+1, c+2.
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    logic [3:0] n;
    assign n = 4'(a_p[c]) + 4'(a_p[c+1]) + 4'(a_p[c+2])
             + 4'(c_p[c])                + 4'(c_p[c+2])
             + 4'(b_p[c]) + 4'(b_p[c+1]) + 4'(b_p[c+2]);
    assign keep[c] = cur[c] & (n >= 4'(NEIGH_THRESH));
  end

  // Popcount of the cells that were occupied but did not survive.
  always_comb begin
    // NOTE: a default before the loop keeps this purely combinational (no latch).
    removed = '0;
    for (int c = 0; c < WIDTH; c++) begin
      removed = removed + RM_W'(cur[c] & ~keep[c]);
    end
  end

endmodule

// File: rtl/day_4_pass_sched.sv
// day_4_pass_sched: streams the grid through a 3-row window, one row per
// cycle, writing eroded rows back until a whole pass removes nothing.
// The "below" row of the window is the RAM read port output itself: a read
// issued for row r+2 in cycle r lands exactly when row r+1 is evaluated.
// Optional build macro DAY4_PART1_EN adds part1_result, the cells removed
// by the first pass.
module day_4_pass_sched
  import day_4_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ROW_AW = 8,
  parameter int CNT_W  = 15,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              finished,
  output logic [CNT_W-1:0]  result,
  output logic [PASS_W-1:0] passes,
`ifdef DAY4_PART1_EN
  output logic [CNT_W-1:0]  part1_result,
`endif
  output logic              mem_rd_en,
  output logic [ROW_AW-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              mem_wr_en,
  output logic [ROW_AW-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data
);

  localparam int              RM_W     = $clog2(WIDTH+1);
  localparam logic [ROW_AW:0] HEIGHT_W = (ROW_AW+1)'(HEIGHT);

  state_e              state_q, state_d;
  logic [ROW_AW-1:0]   row_q, row_d;       // PRIME phase, then STREAM row
  logic [WIDTH-1:0]    above_q, above_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic [CNT_W-1:0]    pass_rm_q, pass_rm_d;
  logic [CNT_W-1:0]    result_q, result_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
`ifdef DAY4_PART1_EN
  logic [CNT_W-1:0]    part1_q, part1_d;
`endif

  logic [WIDTH-1:0]    below;
  logic [WIDTH-1:0]    keep;
  logic [RM_W-1:0]     removed;
  logic                last_row;
  logic                rd_more;

  assign last_row = (row_q == ROW_AW'(HEIGHT-1));
  assign rd_more  = ({1'b0, row_q} + (ROW_AW+1)'(2)) < HEIGHT_W;
  // The last row has no row below; the stale RAM output must not leak in.
  assign below    = (state_q == STREAM && !last_row) ? mem_rd_data : '0;

  day_4_row_eval #(.WIDTH(WIDTH)) u_row_eval (
    .above   (above_q),
    .cur     (cur_q),
    .below   (below),
    .keep    (keep),
    .removed (removed)
  );

  // Next-state, counters and RAM handshakes.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    above_d     = above_q;
    cur_d       = cur_q;
    pass_rm_d   = pass_rm_q;
    result_d    = result_q;
    passes_d    = passes_q;
`ifdef DAY4_PART1_EN
    part1_d     = part1_q;
`endif
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          result_d  = '0;
          passes_d  = '0;
          pass_rm_d = '0;
          row_d     = '0;
`ifdef DAY4_PART1_EN
          part1_d   = '0;
`endif
          state_d   = PRIME;
        end
      end
      PRIME: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = row_q;
        above_d     = '0;
        if (row_q == ROW_AW'(1)) begin
          cur_d   = mem_rd_data;          // row 0, read in the previous cycle
          row_d   = '0;
          state_d = STREAM;
        end else begin
          row_d = row_q + ROW_AW'(1);
        end
      end
      STREAM: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = row_q;
        mem_wr_data = keep;
        pass_rm_d   = pass_rm_q + CNT_W'(removed);
        if (rd_more) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = row_q + ROW_AW'(2);
        end
        // The window keeps the pre-erosion row so the next row sees the old grid.
        above_d = cur_q;
        cur_d   = below;
        if (last_row) begin
          row_d   = '0;
          state_d = CHECK;
        end else begin
          row_d = row_q + ROW_AW'(1);
        end
      end
      CHECK: begin
        result_d  = result_q + pass_rm_q;
        passes_d  = (passes_q == '1) ? passes_q : passes_q + PASS_W'(1);
`ifdef DAY4_PART1_EN
        if (passes_q == '0) part1_d = pass_rm_q;
`endif
        pass_rm_d = '0;
        state_d   = (pass_rm_q == '0) ? DONE : PRIME;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= IDLE;
      row_q     <= '0;
      above_q   <= '0;
      cur_q     <= '0;
      pass_rm_q <= '0;
      result_q  <= '0;
      passes_q  <= '0;
`ifdef DAY4_PART1_EN
      part1_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      above_q   <= above_d;
      cur_q     <= cur_d;
      pass_rm_q <= pass_rm_d;
      result_q  <= result_d;
      passes_q  <= passes_d;
`ifdef DAY4_PART1_EN
      part1_q   <= part1_d;
`endif
    end
  end

  assign busy     = state_q inside {PRIME, STREAM, CHECK};
  assign finished = (state_q == DONE);
  assign result   = result_q;
  assign passes   = passes_q;
`ifdef DAY4_PART1_EN
  assign part1_result = part1_q;
`endif

endmodule

// File: tb/tb_day_4_pass_sched.sv
// tb_day_4_pass_sched: 8x8 grid bench. A behavioural RAM feeds the DUT; a
// whole-grid reference erosion model supplies expected totals, pass counts,
// pass timing and the final grid contents.
module tb_day_4_pass_sched;

  localparam int W        = 8;
  localparam int H        = 8;
  localparam int AW       = 3;
  localparam int CW       = 15;
  localparam int PW       = 8;
  localparam int PASS_CYC = H + 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic          busy, finished;
  logic [CW-1:0] result;
  logic [PW-1:0] passes;
`ifdef DAY4_PART1_EN
  logic [CW-1:0] part1_result;
`endif
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [W-1:0]  mem_rd_data, mem_wr_data;

  logic [W-1:0]  ram [H];
  logic          tb_we   = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [W-1:0]  tb_data = '0;

  bit   [W-1:0]  model [H];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  day_4_pass_sched #(
    .WIDTH(W), .HEIGHT(H), .ROW_AW(AW), .CNT_W(CW), .PASS_W(PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .finished    (finished),
    .result      (result),
    .passes      (passes),
`ifdef DAY4_PART1_EN
    .part1_result(part1_result),
`endif
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );

  // Simple dual-port RAM with one-cycle read latency; the bench loads it
  // through its own write port.
  always @(posedge clk) begin
    if (tb_we)          ram[tb_addr]     <= tb_data;
    else if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en)      mem_rd_data      <= ram[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int neigh(int r, int c);
    int n, rr, cc;
    n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if ((dr != 0 || dc != 0) && rr >= 0 && rr < H && cc >= 0 && cc < W)
          n += int'(model[rr][cc]);
      end
    end
    return n;
  endfunction

  // Whole-grid synchronous erosion until a pass removes nothing.
  task automatic model_run(output int res, output int np, output int p1);
    bit [W-1:0] nxt [H];
    int rm;
    res = 0; np = 0; p1 = 0;
    do begin
      rm = 0;
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          nxt[r][c] = 1'b0;
          if (model[r][c]) begin
            if (neigh(r, c) >= 4) nxt[r][c] = 1'b1;
            else rm++;
          end
        end
      end
      for (int r = 0; r < H; r++) model[r] = nxt[r];
      if (np == 0) p1 = rm;
      np++;
      res += rm;
    end while (rm != 0);
  endtask

  task automatic set_grid(input logic [63:0] v);
    for (int r = 0; r < H; r++) model[r] = v[r*W +: W];
  endtask

  function automatic logic [63:0] pack_ram();
    logic [63:0] v;
    for (int r = 0; r < H; r++) v[r*W +: W] = ram[r];
    return v;
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] v;
    for (int r = 0; r < H; r++) v[r*W +: W] = model[r];
    return v;
  endfunction

  task automatic load_grid();
    for (int r = 0; r < H; r++) begin
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = AW'(r);
      tb_data = model[r];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Start the DUT and count busy cycles until finished, with a cycle budget.
  task automatic run_dut(input bit pulse_mid, output int cyc);
    int guard;
    cyc = 0; guard = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    while (!finished && guard < 5000) begin
      if (busy) cyc++;
      start = (pulse_mid && cyc == 5);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("finished", finished, 1'b1);
  endtask

  task automatic run_case(input string tag, input bit pulse_mid,
                          output int got_res, output int got_np);
    int m_res, m_np, m_p1, cyc;
    load_grid();
    model_run(m_res, m_np, m_p1);
    run_dut(pulse_mid, cyc);
    got_res = int'(result);
    got_np  = int'(passes);
    check({tag, "/result"}, result, m_res);
    check({tag, "/passes"}, passes, m_np);
    check({tag, "/cycles"}, cyc, m_np * PASS_CYC);
    check({tag, "/grid"}, pack_ram(), pack_model());
`ifdef DAY4_PART1_EN
    check({tag, "/part1"}, part1_result, m_p1);
`endif
  endtask

  initial begin
    int res, np;
    logic [W-1:0] a, b;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, finished, result, passes, mem_rd_en, mem_rd_addr,
           mem_wr_en, mem_wr_addr, mem_wr_data}, '0);
    rst = 1'b1;
    @(negedge clk);

    // Empty grid: one pass, nothing removed.
    set_grid(64'h0);
    run_case("empty", 1'b0, res, np);
    check("empty/res_const", res, 0);
    check("empty/passes_const", np, 1);

    // Single isolated cell at row 3, column 4.
    set_grid(64'h0000_0000_1000_0000);
    run_case("isolated", 1'b0, res, np);
    check("isolated/res_const", res, 1);
    check("isolated/passes_const", np, 2);
    check("isolated/row3", ram[3], 8'h00);

    // 3x3 block, with a stray start pulse while busy.
    set_grid(64'h0000_001C_1C1C_0000);
    run_case("block", 1'b1, res, np);
    check("block/res_const", res, 9);
    check("block/passes_const", np, 4);

    // Fully filled grid: only the corners go.
    set_grid('1);
    run_case("full", 1'b0, res, np);
    check("full/res_const", res, 4);
    check("full/passes_const", np, 2);
    check("full/row0", ram[0], 8'h7E);
    check("full/row7", ram[7], 8'h7E);

    // Reset in the STREAM phase of pass 2.
    set_grid(64'h0000_001C_1C1C_0000);
    load_grid();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k < 16; k++) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs",
          {busy, finished, result, passes, mem_rd_en, mem_rd_addr,
           mem_wr_en, mem_wr_addr, mem_wr_data}, '0);
`ifdef DAY4_PART1_EN
    check("midrun_reset_part1", part1_result, '0);
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {busy, finished, result}, '0);
    set_grid(64'h0000_001C_1C1C_0000);
    run_case("restart", 1'b0, res, np);
    check("restart/res_const", res, 9);

    // Randomized grids of varying density.
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < H; r++) begin
        a = W'($urandom);
        b = W'($urandom);
        case (i % 3)
          0:       model[r] = a | b;
          1:       model[r] = a & b;
          default: model[r] = a;
        endcase
      end
      run_case($sformatf("rand%0d", i), (i % 4 == 0), res, np);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/day_4_pass_sched.md
Name: day_4_pass_sched

Overview:
- Pass scheduler for the day-4 grid-erosion computation. The grid lives in an external simple dual-port row RAM, one row of WIDTH bits per word.
- The block streams the grid row by row through a 3-row window and feeds each window to a row-evaluation sub-module. It writes the eroded row back and repeats full passes until a pass removes nothing.
- Reports total removed cells and the number of passes executed. A pass is a one-row-per-cycle pipeline, which replaces the whole-grid combinational array.

Parameters:
- WIDTH, 140, bits per row.
- HEIGHT, 140, number of rows. Must be at least 2.
- ROW_AW, 8, row address width. Must satisfy 2**ROW_AW >= HEIGHT.
- CNT_W, 15, width of cell counters.
- PASS_W, 8, width of the pass counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to run to fixpoint
- busy  out  1  high from the cycle after an accepted start until DONE
- finished  out  1  level; high in DONE until the next accepted start
- result  out  CNT_W  total cells removed over all passes
- passes  out  PASS_W  passes executed, including the final zero-removal pass
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  ROW_AW  RAM read row address
- mem_rd_data  in  WIDTH  RAM read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  ROW_AW  RAM write row address
- mem_wr_data  out  WIDTH  RAM write data

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - busy, finished, result, passes, mem_rd_en and mem_wr_en are 0. Addresses and write data are 0.
  - Window registers are cleared.
- Reset mid-operation: aborts immediately. RAM contents are left partially eroded and are undefined; the bench reloads the grid.
- FSM states: IDLE, PRIME, STREAM, CHECK, DONE.
- IDLE or DONE with start=1:
  - Clear result, passes and finished.
  - Go to PRIME and set busy.
  - start is ignored in PRIME, STREAM and CHECK.
- PRIME (2 cycles): issue reads of row 0 then row 1. The "above" row is zero.
- STREAM (HEIGHT cycles, one per row r = 0..HEIGHT-1):
  - The window holds above = original row r-1 (zero when r=0), cur = row r, below = row r+1 (zero when r=HEIGHT-1).
  - The sub-module returns keep = cur & (8-neighbour count >= 4) and removed = popcount(cur & ~keep).
  - The same cycle writes keep to row r, adds removed to pass_removed, and issues a read of row r+2 if r+2 < HEIGHT.
  - The window then shifts: above <= cur (the pre-erosion value), cur <= below, below <= read data.
  - This preserves synchronous whole-grid semantics: every row of a pass is evaluated against pre-pass neighbours.
  - The RAM must accept a read and a write to different addresses in the same cycle. They never coincide, because the write targets row r and the read targets row r+2.
- CHECK (1 cycle):
  - result += pass_removed; passes += 1 (saturating at all-ones); pass_removed is cleared.
  - If pass_removed == 0, go to DONE. Otherwise go to PRIME.
- DONE: finished=1, busy=0, and outputs hold.
- Timing: each pass is exactly HEIGHT+3 cycles.
- Widths:
  - Neighbour counts are 4-bit.
  - result wraps modulo 2**CNT_W. With the defaults it cannot overflow, since WIDTH*HEIGHT < 2**15.
- Grid edges: columns outside 0..WIDTH-1 and rows outside 0..HEIGHT-1 read as 0.
- Empty grid: one pass; result=0, passes=1.

Optional Feature:
- Macro: DAY4_PART1_EN.
- When defined:
  - Adds output part1_result (CNT_W), which captures pass_removed in the CHECK of pass 1.
  - It is cleared on reset and on accepted start, and holds until the next start.
- When undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package day_4_pkg holds:
  - the state encoding (IDLE=0, PRIME=1, STREAM=2, CHECK=3, DONE=4, 3-bit);
  - the default WIDTH, HEIGHT and NEIGH_THRESH=4.
- One sub-module, day_4_row_eval:
  - purely combinational;
  - inputs: above, cur, below;
  - outputs: keep[WIDTH-1:0] and removed[$clog2(WIDTH+1)-1:0].
- The scheduler owns all sequencing, counters and RAM handshakes.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=8 unless noted.
- All-zero grid, start -> finished after 11+... one pass of 11 cycles; result=0, passes=1, RAM unchanged.
- Single isolated 1 at (3,4) -> result=1, passes=2; row 3 reads back 0.
- Filled 3x3 block at rows 2-4, cols 2-4:
  - pass 1 removes the 4 corners, pass 2 the 4 edges, pass 3 the centre, pass 4 nothing;
  - result=9, passes=4, part1_result=4 (with DAY4_PART1_EN);
  - finished rises 44 cycles after busy.
- Fully filled 8x8 -> only the 4 corners are removed; result=4, passes=2; rows 0 and 7 read back 0x7E.
- Reset asserted in STREAM of pass 2, then start -> all outputs 0 on the reset cycle; busy, finished and result are 0 until restart; start pulses during busy are ignored (passes unaffected).
- Default 140x140 with the puzzle input -> result matches the golden model, and each pass lasts exactly 143 cycles.
